toggle_pair_gen: RTL
====================

TOGGLE_PAIR_GEN -- requirements
Module: toggle_pair_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of a_out/b_out (1..16).
REQ-002 SHALL have parameter SEED, default 16'hACE1, LFSR start value (nonzero).
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per burst (1..65535).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin burst, sampled in IDLE only.
REQ-007 SHALL have port stop  input  1  request early burst end.
REQ-008 SHALL have port ready  input  1  sink accepts beat.
REQ-009 SHALL have port valid  output  1  beat on a_out/b_out is offered.
REQ-010 SHALL have port a_out, b_out  output  WIDTH  matched word pair.
REQ-011 SHALL have port c_out, d_out  output  1  toggle pair, per-cycle.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port count  output  16  beats accepted this burst.
REQ-014 SHALL have port done  output  1  one-cycle end-of-burst pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN (start) -> DONE (last beat accepted or stop serviced) -> IDLE (unconditional, next cycle).
REQ-016 SHALL raise valid the cycle after start is sampled in IDLE, with a_out = b_out = SEED[WIDTH-1:0].
REQ-017 SHALL hold valid, a_out, b_out stable until valid && ready; valid never drops without acceptance.
REQ-018 SHALL, on each accept, advance a 16-bit Galois LFSR (poly 16'hB400), increment count, present the next word next cycle (zero-bubble with ready held high).
REQ-019 SHALL drive a_out == b_out on every valid cycle (config excepted).
REQ-020 SHALL, in RUN, toggle an internal phase bit every clock regardless of handshake; c_out = LFSR bit 0; d_out = c_out when phase=1, ~c_out when phase=0.
REQ-021 SHALL guarantee: any cycle with c_out == d_out is followed by a cycle with c_out != d_out, including on the RUN->DONE and DONE->IDLE transitions.
REQ-022 SHALL drive c_out=0, d_out=1 in IDLE and DONE.
REQ-023 SHALL, on stop in RUN, latch stop_pending; burst ends at next accept; if stop and accept coincide, that beat is the last.
REQ-024 SHALL enter DONE when count reaches BURST_LEN on accept; done=1 in DONE only; count holds final value until next start.
REQ-025 SHALL ignore start outside IDLE and stop outside RUN; start and stop together in IDLE starts a burst.
REQ-026 SHALL clear count to 0 and reload the LFSR with SEED on each accepted start.

Reset
REQ-027 SHALL on reset_n low, immediately: state=IDLE, valid=0, a_out=b_out=0, c_out=0, d_out=1, busy=0, count=0, done=0, phase=0, stop_pending=0, LFSR=SEED.
REQ-028 SHALL abandon any in-flight beat on mid-burst reset; no done pulse generated.

Configuration
REQ-029 SHALL, with TOGGLE_PAIR_GEN_MISMATCH_EN defined, add input inject_err (1 bit); when high on a cycle valid first rises for a beat, that beat carries b_out = ~a_out, held until accepted.
REQ-030 SHALL, without TOGGLE_PAIR_GEN_MISMATCH_EN, omit inject_err; b_out always equals a_out.

Structure
REQ-031 SHALL place state enum, LFSR polynomial constant and default seed in package toggle_pair_pkg.
REQ-032 SHALL instantiate sub-module lfsr16_step (combinational next-state of the 16-bit Galois LFSR).

Verification
REQ-033 Reset, start pulse, ready=1, BURST_LEN=8 -> valid cycles 2..9, first a_out=b_out=16'hACE1, count=8, done pulse cycle 10, then IDLE.
REQ-034 ready low 3 cycles mid-burst -> a_out/b_out/valid stable all 3 cycles; c/d pair still alternates per REQ-021.
REQ-035 stop asserted same cycle as 3rd accept -> done next cycle, count=3.
REQ-036 reset_n low during beat 4 -> outputs at reset values same cycle; new start restarts at 16'hACE1, count from 0.
REQ-037 Concurrent assertions every cycle: valid -> a_out == b_out; (c_out === d_out) |=> (c_out !== d_out); zero failures over 10k random ready/stop cycles.
REQ-038 With TOGGLE_PAIR_GEN_MISMATCH_EN, inject_err on beat 2 -> b_out == ~a_out on that beat only; match assertion fires exactly once.

Source files
------------

// File: rtl/toggle_pair_pkg.sv
// Shared types and constants for the toggle-pair burst generator.
package toggle_pair_pkg;

  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned CNT_W        = 16;
  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Burst controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One beat as presented on the a/b output pair (full LFSR width)
  typedef struct packed {
    logic [LFSR_W-1:0] a;
    logic [LFSR_W-1:0] b;
  } beat_t;

endpackage

// File: rtl/toggle_pair_gen_lfsr16_step.sv
// Combinational next-state of the 16-bit right-shifting Galois LFSR.
module lfsr16_step
  import toggle_pair_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] next_o
);

  // Shift right; fold the polynomial in when the outgoing bit is set
  always_comb begin
    next_o = {1'b0, state_i[LFSR_W-1:1]};
    if (state_i[0]) begin
      next_o = next_o ^ LFSR_POLY;
    end
  end

endmodule

// File: rtl/toggle_pair_gen.sv
// Burst generator: emits BURST_LEN LFSR words as a matched a/b pair over a
// valid/ready handshake, plus a c/d toggle pair that never shows equal
// values on two consecutive cycles.
// Optional feature macro TOGGLE_PAIR_GEN_MISMATCH_EN adds input inject_err:
// when high on the clock edge that loads a new beat onto a_out/b_out (the
// edge at which valid first rises for that beat), the beat carries
// b_out = ~a_out until it is accepted.
module toggle_pair_gen
  import toggle_pair_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             ready,
`ifdef TOGGLE_PAIR_GEN_MISMATCH_EN
  input  logic             inject_err,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             c_out,
  output logic             d_out,
  output logic             busy,
  output logic [15:0]      count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              spend_q, spend_d;
  logic              phase_q, phase_d;
  logic              valid_q, valid_d;
  beat_t             beat_q, beat_d;
  logic              c_q, c_d;
  logic              d_q, d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_acc_c;
  logic              accept_c;
  logic              last_c;
  logic              corrupt_c;

  lfsr16_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_step)
  );

`ifdef TOGGLE_PAIR_GEN_MISMATCH_EN
  assign corrupt_c = inject_err;
`else
  assign corrupt_c = 1'b0;
`endif

  // Handshake qualifiers; a pending or coincident stop makes this accept the last
  assign start_acc_c = (state_q == ST_IDLE) && start;
  assign accept_c    = (state_q == ST_RUN) && valid_q && ready;
  assign last_c      = accept_c && ((cnt_q == LAST_CNT) || spend_q || stop);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE:             state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values, all derived from the upcoming state
  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    spend_d = spend_q;
    phase_d = 1'b0;
    beat_d  = beat_q;
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    c_d     = 1'b0;
    d_d     = 1'b1;

    if (start_acc_c) begin
      lfsr_d  = SEED;
      cnt_d   = '0;
      spend_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (stop) begin
        spend_d = 1'b1;
      end
      if (accept_c) begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      if (last_c) begin
        spend_d = 1'b0;
      end
    end

    // Phase only runs while staying in RUN; each burst starts at phase 0
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      phase_d = ~phase_q;
    end

    // A new beat is loaded on start or on a non-final accept
    if ((state_d == ST_RUN) && (start_acc_c || accept_c)) begin
      beat_d.a = lfsr_d;
      beat_d.b = corrupt_c ? ~lfsr_d : lfsr_d;
    end

    if (state_d == ST_RUN) begin
      c_d = lfsr_d[0];
      d_d = phase_d ? lfsr_d[0] : ~lfsr_d[0];
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      spend_q <= 1'b0;
      phase_q <= 1'b0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= 1'b1;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      spend_q <= spend_d;
      phase_q <= phase_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign valid = valid_q;
  assign a_out = beat_q.a[WIDTH-1:0];
  assign b_out = beat_q.b[WIDTH-1:0];
  assign c_out = c_q;
  assign d_out = d_q;
  assign busy  = busy_q;
  assign count = cnt_q;
  assign done  = done_q;

endmodule
